// File: rtl/mult_div_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encodings, iteration count and operand helpers.
package mult_div_pkg;

  // operation[1]: 1 = divide, 0 = multiply; operation[0]: 1 = signed
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Iteration down-counter start value; the last BUSY cycle is at count 0.
  localparam logic [4:0] CNT_START = 5'd31;

  // Unsigned magnitude of an operand; 0x80000000 maps to 2^31 unchanged.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit. One shift-add (multiply) or
// restoring (divide) step per BUSY cycle on operand magnitudes, sharing one
// 64-bit accumulator and one 33-bit adder. Signs are fixed up when the final
// step is written to `out`.
//
// state | meaning
// IDLE  | waiting for enable; operands latched on the start edge
// BUSY  | 32 iterations, counter runs 31 -> 0
// DONE  | one cycle with result on out; enable ignored
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] value_1,
  input  logic [31:0] value_2,
  input  logic [1:0]  operation,
  output logic [63:0] out,
  output logic        in_operation
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;        // {hi, lo}: product / {remainder, quotient}
  logic [31:0] opb_q, opb_d;        // multiplicand or divisor magnitude
  logic [31:0] dvd_q, dvd_d;        // raw value_1, returned on divide by zero
  logic        div_q, div_d;
  logic        neg_q, neg_d;        // product / quotient sign
  logic        rem_neg_q, rem_neg_d;
  logic        div0_q, div0_d;
  logic [63:0] out_q, out_d;
  logic        busy_c;

  logic [32:0] add_a, add_b, sum;
  logic [63:0] step;
  logic [63:0] result;
  logic        sgn_c, sa_c, sb_c;

  // Shared adder: adds multiplicand to hi for multiply, subtracts divisor
  // from the shifted partial remainder for divide.
  always_comb begin
    add_a = div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    if (div_q)
      add_b = ~{1'b0, opb_q};
    else
      add_b = acc_q[0] ? {1'b0, opb_q} : 33'd0;
    sum = add_a + add_b + {32'd0, div_q};
  end

  // Next accumulator value for one iteration, plus the signed final result.
  always_comb begin
    if (div_q) begin
      if (!sum[32])
        step = {sum[31:0], acc_q[30:0], 1'b1};
      else
        step = {acc_q[62:0], 1'b0};
    end else begin
      step = {sum, acc_q[31:1]};
    end

    if (div_q) begin
      if (div0_q)
        result = {dvd_q, 32'hFFFF_FFFF};
      else
        result = {(rem_neg_q ? (~step[63:32] + 32'd1) : step[63:32]),
                  (neg_q     ? (~step[31:0]  + 32'd1) : step[31:0])};
    end else begin
      result = neg_q ? (~step + 64'd1) : step;
    end
  end

  // FSM next state, operand capture and busy flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    dvd_d     = dvd_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    out_d     = out_q;
    busy_c    = 1'b0;
    sgn_c     = op_is_signed(operation);
    sa_c      = sgn_c & value_1[31];
    sb_c      = sgn_c & value_2[31];

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          busy_c    = 1'b1;
          state_d   = ST_BUSY;
          cnt_d     = CNT_START;
          div_d     = op_is_div(operation);
          neg_d     = sa_c ^ sb_c;
          rem_neg_d = sa_c;
          acc_d     = {32'd0, magnitude(value_1, sgn_c)};
          opb_d     = magnitude(value_2, sgn_c);
          dvd_d     = value_1;
          div0_d    = (value_2 == 32'd0);
        end
      end
      ST_BUSY: begin
        busy_c = 1'b1;
        acc_d  = step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
          cnt_d   = 5'd0;
          out_d   = result;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_operation = rst_n & busy_c;
  assign out          = out_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      dvd_q     <= 32'd0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      out_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      dvd_q     <= dvd_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products, quotients and
// remainders, busy-window length, enable held through DONE, mid-op reset.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] value_1;
  logic [31:0] value_2;
  logic [1:0]  operation;
  logic [63:0] out;
  logic        in_operation;

  int          n_checks;
  int          n_errors;
  logic [63:0] prev_out;

  mult_div_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .value_1      (value_1),
    .value_2      (value_2),
    .operation    (operation),
    .out          (out),
    .in_operation (in_operation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Starts an operation from IDLE (called #1 after a rising edge), counts
  // the busy window, checks the result, and leaves the unit back in IDLE.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit hold);
    int cycles;
    operation = op;
    value_1   = a;
    value_2   = b;
    enable    = 1'b1;
    #1;
    cycles = 0;
    while (in_operation === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
      if (cycles == 10) check({tag, " out_stable"}, out, prev_out);
    end
    check({tag, " busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, " result"}, out, exp);
    prev_out = exp;
    if (!hold) enable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    prev_out  = 64'd0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    value_1   = 32'd0;
    value_2   = 32'd0;
    operation = 2'b00;

    #1;
    check("reset_busy_low", 64'(in_operation), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 64'd0);
    check("reset_busy_low2", 64'(in_operation), 64'd0);
    enable = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    check("idle_busy_low", 64'(in_operation), 64'd0);

    run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult_m3x7",  2'b01, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("mult_min2",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op("mult_negneg",2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 1'b0);
    run_op("mult_7xm1",  2'b01, 32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    run_op("multu_zero", 2'b00, 32'h1234_5678, 32'd0,         64'h0000_0000_0000_0000, 1'b0);
    run_op("multu_big",  2'b00, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 1'b0);
    run_op("div_m7d2",   2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_7dm2",   2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("divu_100d7", 2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0);
    run_op("divu_by0",   2'b10, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b0);
    run_op("div_by0",    2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b0);
    run_op("div_neg_by0",2'b11, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
    run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);

    // Enable held through DONE: no restart in DONE, immediate start in IDLE.
    run_op("hold_a", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1);
    check("hold_restart_busy", 64'(in_operation), 64'd1);
    check("hold_out_kept", out, 64'h0000_0002_0000_000E);
    run_op("hold_b", 2'b00, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0);

    // Reset in the middle of BUSY aborts and clears out.
    operation = 2'b00;
    value_1   = 32'd9;
    value_2   = 32'd9;
    enable    = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("midop_busy", 64'(in_operation), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_busy_low", 64'(in_operation), 64'd0);
    @(posedge clk); #1;
    check("midop_rst_out", out, 64'd0);
    check("midop_rst_busy_low2", 64'(in_operation), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(in_operation), 64'd0);
    prev_out = 64'd0;
    run_op("post_rst_mult", 2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 64'h0000_0000_0000_0009, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset; one clock, and reset is synchronous and active-low.
REQ-003 enable  in  1  level request to start an operation; held high by the pipeline for as long as the instruction sits in EX.
REQ-004 value_1  in  32  multiplicand / dividend.
REQ-005 value_2  in  32  multiplier / divisor.
REQ-006 operation  in  2  bit1: 1 = divide, 0 = multiply; bit0: 1 = signed, 0 = unsigned (00 multu, 01 mult, 10 divu, 11 div).
REQ-007 out  out  64  result; out[63:32] = HI, out[31:0] = LO.
REQ-008 in_operation  out  1  busy/stall flag; its falling edge marks `out` as valid.

Function
REQ-009 The block SHALL implement an FSM with three states:
- IDLE -> BUSY when enable=1; operands and operation are latched at that edge.
- BUSY -> DONE after 32 iterations.
- DONE -> IDLE unconditionally after one cycle.
REQ-010 in_operation SHALL be combinational: 1 when (IDLE and enable=1) or BUSY; 0 in DONE and in IDLE with enable=0.
REQ-011 in_operation SHALL therefore rise in the same cycle enable first rises, with no cycle gap, so the pipeline stalls immediately.
REQ-012 in_operation SHALL be high for exactly 33 cycles per operation: the enable cycle plus 32 BUSY cycles.
REQ-013 enable SHALL be ignored in DONE, so the still-present instruction does not restart the unit.
REQ-014 enable SHALL be ignored in BUSY; operands latched at start are used throughout.
REQ-015 Multiply: one shift-add iteration per BUSY cycle on operand magnitudes; out = full 64-bit product.
REQ-016 Signed multiply SHALL negate the product when the operand signs differ; 0x80000000 SHALL be handled as magnitude 2^31.
REQ-017 Divide: one restoring iteration per BUSY cycle; out[31:0] = quotient, out[63:32] = remainder.
REQ-018 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign.
REQ-019 Signed divide -2^31 / -1 SHALL give quotient 0x80000000, remainder 0.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = value_1, for both the signed and unsigned forms.
REQ-021 out SHALL be updated at the BUSY->DONE edge.
REQ-022 out SHALL hold stable from DONE until the next operation completes; intermediate values SHALL NOT appear on out.
REQ-023 Back-to-back operations SHALL be supported: a new enable arriving in IDLE the cycle after DONE starts immediately.

Reset
REQ-024 While rst_n=0 at a rising edge: state -> IDLE, iteration counter -> 0, out -> 0, internal operand/accumulator registers -> 0.
REQ-025 While rst_n=0, in_operation SHALL read 0, regardless of enable.
REQ-026 Reset asserted during BUSY SHALL abort the operation; out SHALL become 0.

Structure
REQ-027 Operation encodings (MULTU/MULT/DIVU/DIV) and FSM state encodings SHALL be constants in a shared package, mult_div_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; the datapath SHALL share one 64-bit accumulator and one 33-bit adder/subtractor between multiply and divide.

Verification
REQ-029 Unsigned multiply: operation=00, 0xFFFFFFFF*0xFFFFFFFF -> out=0xFFFFFFFE00000001; in_operation high for exactly 33 cycles.
REQ-030 Signed multiply: operation=01, -3*7 -> out=0xFFFFFFFFFFFFFFEB; operation=01, 0x80000000*0x80000000 -> out=0x4000000000000000.
REQ-031 Signed divide: operation=11, -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 Unsigned divide: operation=10, 100/7 -> LO=14, HI=2.
REQ-033 Divide by zero: 5/0 with either divide encoding -> LO=0xFFFFFFFF, HI=5.
REQ-034 enable held high through DONE -> no restart; then enable high the cycle after DONE -> new op starts; out unchanged until that op completes.
REQ-035 rst_n pulsed low mid-BUSY -> in_operation=0 and out=0 the next cycle.
